// File: rtl/ysyx_23060020_lsu.sv
// Load/store unit: one RV32 load/store per handshake against a word-wide
// memory port with combinational read and full-word write. Sub-word stores
// are read-modify-write; misaligned/illegal requests answer with an error
// and never touch memory.
module ysyx_23060020_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        wen_q, wen_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign in_ready = (state_q == IDLE) && !rst;

  // Classify the incoming request before it is accepted.
  always_comb begin
    if (in_wen) begin
      req_illegal = in_funct3[2] || (in_funct3[1:0] == 2'b11);
    end else begin
      req_illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
                    (in_funct3 == 3'b111);
    end
    req_misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane merge for sub-word stores, both
  // straight from the combinational read data during the RD cycle, so the
  // read word never needs its own buffer register.
  always_comb begin
    shifted = mem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    merged = mem_rdata;
    if (funct3_q[0]) begin
      merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Next-state logic; memory controls are computed one cycle early so the
  // port sees registered values for the whole access cycle.
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    wen_d       = wen_q;
    rd_d        = rd_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_valid_d = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          addr_lo_d  = in_addr[1:0];
          wdata_d    = in_wdata;
          funct3_d   = in_funct3;
          wen_d      = in_wen;
          rd_d       = in_rd;
          rdata_d    = 32'd0;
          err_d      = 1'b0;
          mem_addr_d = {in_addr[31:2], 2'b00};
          if (req_illegal || req_misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (in_wen && (in_funct3 == 3'b010)) begin
            mem_valid_d = 1'b1;
            mem_wen_d   = 1'b1;
            mem_wdata_d = in_wdata;
            state_d     = WR;
          end else begin
            mem_valid_d = 1'b1;
            state_d     = RD;
          end
        end
      end
      RD: begin
        if (wen_q) begin
          mem_valid_d = 1'b1;
          mem_wen_d   = 1'b1;
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_lo_q   <= 2'd0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      wen_q       <= 1'b0;
      rd_q        <= 5'd0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      wen_q       <= wen_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign out_valid = (state_q == RESP);
  assign out_rdata = rdata_q;
  assign out_rd    = rd_q;
  assign out_err   = err_q;

  // Memory port is silenced while reset is held so an in-flight write is
  // never issued during a reset cycle.
  assign mem_valid = mem_valid_q && !rst;
  assign mem_wen   = mem_wen_q && !rst;
  assign mem_addr  = rst ? 32'd0 : mem_addr_q;
  assign mem_wdata = rst ? 32'd0 : mem_wdata_q;

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Directed testbench for ysyx_23060020_lsu with a small word memory model.
module tb_ysyx_23060020_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'd0;
  int          nrd = 0;
  int          nwr = 0;
  logic [31:0] last_raddr = 32'd0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  always #5 clk = ~clk;

  ysyx_23060020_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_err(out_err),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  // Memory model: combinational read, full-word write, access counters.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    if (mem_valid) begin
      if (mem_wen) begin
        nwr        <= nwr + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
        mem[mem_addr[5:2]] <= mem_wdata;
      end else begin
        nrd        <= nrd + 1;
        last_raddr <= mem_addr;
      end
    end
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request; returns cycles from accept edge to out_valid (-1 on timeout).
  task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 6; c++) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL reset_out got valid=%b err=%b want 0/0", out_valid, out_err); end
    checks++; if (out_rdata !== 32'd0 || out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_data got rdata=%h rd=%0d want 0/0", out_rdata, out_rd); end
    checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++; $display("FAIL reset_mem got v=%b w=%b a=%h d=%h want all 0", mem_valid, mem_wen, mem_addr, mem_wdata); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_lw();
    int lat, r0, w0;
    preload(4'd1, 32'hDEADBEEF);
    r0 = nrd; w0 = nwr;
    run_req(1'b0, 3'b010, 32'h80000004, 32'd0, 5'd5, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d want=2", lat); end
    checks++; if (out_rdata !== 32'hDEADBEEF || out_err !== 1'b0 || out_rd !== 5'd5) begin
      failures++; $display("FAIL lw_resp got rdata=%h err=%b rd=%0d want deadbeef/0/5", out_rdata, out_err, out_rd); end
    checks++; if (nrd - r0 !== 1 || nwr - w0 !== 0 || last_raddr !== 32'h80000004) begin
      failures++; $display("FAIL lw_mem got reads=%0d writes=%0d addr=%h want 1/0/80000004", nrd - r0, nwr - w0, last_raddr); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lw_resp_in_ready got=%b want=0", in_ready); end
    consume();
    $display("lw: lat=%0d rdata=%h", lat, out_rdata);
  endtask

  task automatic test_load_ext();
    int lat;
    logic [31:0] addrs [4];
    logic [2:0]  f3s [4];
    logic [31:0] exp [4];
    addrs = '{32'h80000007, 32'h80000007, 32'h80000006, 32'h80000006};
    f3s   = '{3'b000, 3'b100, 3'b001, 3'b101};
    exp   = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    preload(4'd1, 32'h80FF1234);
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3s[i], addrs[i], 32'd0, 5'd7, lat);
      checks++; if (lat !== 2 || out_rdata !== exp[i] || out_err !== 1'b0) begin
        failures++; $display("FAIL load_ext[%0d] got lat=%0d rdata=%h err=%b want 2/%h/0", i, lat, out_rdata, out_err, exp[i]); end
      $display("load f3=%b addr=%h: rdata=%h", f3s[i], addrs[i], out_rdata);
      consume();
    end
  endtask

  task automatic test_sub_store();
    int lat, r0, w0;
    preload(4'd0, 32'h11223344);
    r0 = nrd; w0 = nwr;
    run_req(1'b1, 3'b000, 32'h80000001, 32'h000000AB, 5'd1, lat);
    checks++; if (lat !== 3 || out_rdata !== 32'd0 || out_err !== 1'b0) begin
      failures++; $display("FAIL sb_resp got lat=%0d rdata=%h err=%b want 3/0/0", lat, out_rdata, out_err); end
    checks++; if (nrd - r0 !== 1 || nwr - w0 !== 1 || last_wdata !== 32'h1122AB44 || last_waddr !== 32'h80000000) begin
      failures++; $display("FAIL sb_mem got reads=%0d writes=%0d wdata=%h waddr=%h want 1/1/1122ab44/80000000", nrd - r0, nwr - w0, last_wdata, last_waddr); end
    consume();
    $display("sb: lat=%0d wdata=%h", lat, last_wdata);
    run_req(1'b1, 3'b001, 32'h80000002, 32'hFFFF5566, 5'd2, lat);
    checks++; if (lat !== 3 || last_wdata !== 32'h5566AB44 || mem[0] !== 32'h5566AB44) begin
      failures++; $display("FAIL sh_mem got lat=%0d wdata=%h mem=%h want 3/5566ab44", lat, last_wdata, mem[0]); end
    consume();
    $display("sh: lat=%0d wdata=%h", lat, last_wdata);
  endtask

  task automatic test_sw();
    int lat, r0, w0;
    r0 = nrd; w0 = nwr;
    run_req(1'b1, 3'b010, 32'h80000008, 32'hCAFEF00D, 5'd3, lat);
    checks++; if (lat !== 2 || out_rdata !== 32'd0 || out_err !== 1'b0 || out_rd !== 5'd3) begin
      failures++; $display("FAIL sw_resp got lat=%0d rdata=%h err=%b rd=%0d want 2/0/0/3", lat, out_rdata, out_err, out_rd); end
    checks++; if (nrd - r0 !== 0 || nwr - w0 !== 1 || last_wdata !== 32'hCAFEF00D || last_waddr !== 32'h80000008) begin
      failures++; $display("FAIL sw_mem got reads=%0d writes=%0d wdata=%h waddr=%h want 0/1/cafef00d/80000008", nrd - r0, nwr - w0, last_wdata, last_waddr); end
    consume();
    $display("sw: lat=%0d wdata=%h", lat, last_wdata);
  endtask

  task automatic test_errors();
    int lat, r0, w0;
    logic        wens [4];
    logic [2:0]  f3s [4];
    logic [31:0] addrs [4];
    wens  = '{1'b0, 1'b1, 1'b0, 1'b1};
    f3s   = '{3'b010, 3'b001, 3'b011, 3'b011};
    addrs = '{32'h80000002, 32'h80000003, 32'h80000004, 32'h80000004};
    for (int i = 0; i < 4; i++) begin
      r0 = nrd; w0 = nwr;
      run_req(wens[i], f3s[i], addrs[i], 32'h12345678, 5'd9, lat);
      checks++; if (lat !== 1 || out_err !== 1'b1 || out_rdata !== 32'd0) begin
        failures++; $display("FAIL err[%0d] got lat=%0d err=%b rdata=%h want 1/1/0", i, lat, out_err, out_rdata); end
      consume();
      checks++; if (nrd !== r0 || nwr !== w0) begin
        failures++; $display("FAIL err_mem[%0d] got reads=%0d writes=%0d want 0/0", i, nrd - r0, nwr - w0); end
      $display("err wen=%b f3=%b addr=%h: lat=%0d", wens[i], f3s[i], addrs[i], lat);
    end
  endtask

  task automatic test_stall();
    int lat;
    preload(4'd1, 32'h80FF1234);
    out_ready = 1'b0;
    run_req(1'b0, 3'b010, 32'h80000004, 32'd0, 5'd9, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL stall_latency got=%0d want=2", lat); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_rdata !== 32'h80FF1234 || out_rd !== 5'd9 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] got v=%b rdata=%h rd=%0d err=%b rdy=%b", i, out_valid, out_rdata, out_rd, out_err, in_ready); end
    end
    out_ready = 1'b1;
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    $display("stall: rdata=%h held 4 cycles", out_rdata);
  endtask

  task automatic test_reset_in_wr();
    int w0;
    preload(4'd3, 32'd0);
    w0 = nwr;
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b1; in_funct3 = 3'b010; in_addr = 32'h8000000C;
    in_wdata = 32'h12345678; in_rd = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1 || mem_wen !== 1'b1) begin
      failures++; $display("FAIL wr_cycle got v=%b w=%b want 1/1", mem_valid, mem_wen); end
    rst = 1'b1; #1;
    checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0) begin
      failures++; $display("FAIL rst_wr_mem got v=%b w=%b want 0/0", mem_valid, mem_wen); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || nwr !== w0 || mem[3] !== 32'd0) begin
      failures++; $display("FAIL rst_wr_after got v=%b rdy=%b writes=%0d mem=%h want 0/1/0/0", out_valid, in_ready, nwr - w0, mem[3]); end
    repeat (3) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || mem_valid !== 1'b0) begin
      failures++; $display("FAIL rst_wr_dropped got v=%b mv=%b want 0/0", out_valid, mem_valid); end
    $display("reset in WR: response dropped");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; out_ready = 1'b1;
    test_reset();
    test_lw();
    test_load_ext();
    test_sub_store();
    test_sw();
    test_errors();
    test_stall();
    test_reset_in_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060020_lsu.md
# ysyx_23060020_lsu

Load/store unit between the execute stage and the `ysyx_23060020_mem` port. Accepts one RV32 load/store per handshake, drives the word-wide memory port (combinational read, full-word write, no byte mask), and returns aligned, extended load data or store completion to writeback. Sub-word stores are done as read-modify-write. Misaligned or illegal accesses are reported without touching memory.

## Interface
- Parameters: none (XLEN fixed at 32).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid from EXU.
- `in_ready` out 1: LSU can accept; `(state==IDLE) && !rst`.
- `in_wen` in 1: 1 = store, 0 = load.
- `in_funct3` in 3: RV32 funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- `in_addr` in 32: byte address.
- `in_wdata` in 32: store data (rs2).
- `in_rd` in 5: destination tag, returned unchanged.
- `out_valid` out 1: response valid.
- `out_ready` in 1: writeback accepts response.
- `out_rdata` out 32: extended load data; 0 for stores and errors.
- `out_rd` out 5: captured `in_rd`.
- `out_err` out 1: misaligned address or illegal funct3.
- `mem_valid` out 1: memory access enable (to `memvalid`).
- `mem_wen` out 1: memory write enable (to `wen`).
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: combinational read data, valid in the same cycle as `mem_valid`.

## Operation
- States: IDLE, RD, WR, RESP. Reset -> IDLE.
- IDLE: on `in_valid && in_ready`, latch addr, wdata, funct3, wen, rd. Next state:
  - illegal funct3 (load 011/110/111, store ≥011) or misaligned (H with addr[0]=1; W with addr[1:0]≠0) -> RESP, err=1, no memory access.
  - load, SB, SH -> RD.
  - SW -> WR.
- RD: `mem_valid=1, mem_wen=0`; register `mem_rdata` into word buffer. Load -> RESP. SB/SH -> WR.
- WR: `mem_valid=1, mem_wen=1`. `mem_wdata`: SW = wdata; SB = buffer with byte lane addr[1:0] replaced by wdata[7:0]; SH = buffer with halfword lane addr[1] replaced by wdata[15:0]. -> RESP.
- RESP: `out_valid=1`; stay until `out_ready`, then -> IDLE. No accept in the same cycle (`in_ready=0` in RESP).
- Load extraction: shift buffer right by 8*addr[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
- `mem_valid=0` in IDLE and RESP; `mem_wen=1` only in WR. Exactly one write per store, none per load or error.

## Timing
- Reset values: state IDLE; `out_valid=0, out_err=0, out_rdata=0, out_rd=0, mem_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0`; `in_ready=0` while `rst=1`.
- Latency (accept edge = cycle 0): load / SW -> `out_valid` in cycle 2; SB/SH -> cycle 3; error -> cycle 1.
- Memory outputs are registered from latched request and state, stable for the whole access cycle.
- `out_*` are held stable while `out_valid && !out_ready`.
- Reset during RD/WR/RESP: next edge -> IDLE, response dropped. All `mem_*` outputs are forced 0 while `rst=1`, so no write is issued in a reset cycle.
- Throughput: one request per 3 cycles for loads/SW with `out_ready=1` (no back-to-back accept from RESP).

## Test plan
- LW 0x80000004, memory word 0xDEADBEEF, out_ready=1 -> one read cycle at mem_addr 0x80000004, out_valid in cycle 2, out_rdata 0xDEADBEEF, err 0.
- LB/LBU at 0x80000007 over word 0x80FF1234 -> LB 0xFFFFFF80, LBU 0x00000080; LH at 0x80000006 -> 0xFFFF80FF.
- SB 0x80000001, wdata 0x000000AB, old word 0x11223344 -> RD then WR cycle, mem_wdata 0x1122AB44, out_valid cycle 3, out_rdata 0.
- SW 0x80000008, wdata 0xCAFEF00D -> no read cycle, single write 0xCAFEF00D, out_valid cycle 2.
- LW 0x80000002 and SH 0x80000003 -> out_err 1 in cycle 1, mem_valid never asserted; funct3 011 load -> same.
- Load with out_ready held 0 for 4 cycles -> out_* stable, in_ready 0; rst asserted in a WR cycle -> mem_valid 0 that cycle, IDLE next, no response.
